// File: rtl/count_display_scan.sv
// rtl/count_display_scan.sv - samples a 4-bit count, scans tens/units onto a 2-digit active-low 7-seg display, flags wraps.
// Optional LEADING_ZERO_BLANK_EN: a tens digit of zero leaves the TENS slot dark.
module count_display_scan #(
  parameter int REFRESH_W = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic       CLK,
  input  logic       Clear,
  input  logic [3:0] Count,
  output logic [6:0] Seg,
  output logic [1:0] An,
  output logic       WrapUp,
  output logic       WrapDown
);

  localparam int CNT_W = REFRESH_W + $clog2(BLANK_CYC + 1) + 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'((2 ** REFRESH_W) - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  localparam logic [1:0] BLANK_U = 2'd0;
  localparam logic [1:0] UNITS   = 2'd1;
  localparam logic [1:0] BLANK_T = 2'd2;
  localparam logic [1:0] TENS    = 2'd3;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;

  logic [3:0]       count_q;
  logic [3:0]       prev_q;
  logic             sampled;
  logic             primed;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             slot_last;
  logic             tens;
  logic [3:0]       units;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  always_comb begin
    tens  = (count_q >= 4'd10);
    units = tens ? (count_q - 4'd10) : count_q;
  end

  // primed needs two samples so prev_q holds a real post-reset value
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      count_q  <= 4'd0;
      prev_q   <= 4'd0;
      sampled  <= 1'b0;
      primed   <= 1'b0;
      WrapUp   <= 1'b0;
      WrapDown <= 1'b0;
    end else begin
      count_q  <= Count;
      prev_q   <= count_q;
      sampled  <= 1'b1;
      primed   <= sampled;
      WrapUp   <= primed && (prev_q == 4'd15) && (count_q == 4'd0);
      WrapDown <= primed && (prev_q == 4'd0) && (count_q == 4'd15);
    end
  end

  always_comb begin
    slot_last = 1'b0;
    if ((state == UNITS) || (state == TENS))
      slot_last = (cnt == SLOT_LAST);
    else
      slot_last = (cnt == BLANK_LAST);
  end

  // state encoding is ordered so the scan advances by simple increment
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      state <= BLANK_U;
      cnt   <= '0;
    end else if (slot_last) begin
      state <= state + 2'd1;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // digit captured on the first cycle of a slot, then held until the slot ends
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      Seg <= SEG_OFF;
      An  <= AN_OFF;
    end else begin
      case (state)
        UNITS: begin
          if (cnt == '0) begin
            Seg <= seg_code(units);
            An  <= 2'b10;
          end
        end
        TENS: begin
          if (cnt == '0) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (!tens) begin
              Seg <= SEG_OFF;
              An  <= AN_OFF;
            end else begin
              Seg <= seg_code({3'b000, tens});
              An  <= 2'b01;
            end
`else
            Seg <= seg_code({3'b000, tens});
            An  <= 2'b01;
`endif
          end
        end
        default: begin
          Seg <= SEG_OFF;
          An  <= AN_OFF;
        end
      endcase
    end
  end

endmodule
